// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port into a valid/ready stream.
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency.
module fifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [1:0]       occ, occ_nxt;
    logic             inflight;
    logic [WIDTH-1:0] slot0, slot1, slot0_nxt, slot1_nxt;
    logic             pop;
    logic [2:0]       pending;

    // Handshake: a word transfers on every edge where m_valid and m_ready are
    // both high; m_valid and m_data are held until that happens (or flush/reset).
    assign m_valid = (occ != 2'd0);
    assign m_data  = slot0;
    assign pop     = m_valid & m_ready;
    assign busy    = (state != ST_IDLE);

    // Words owned after this edge's pop; a new read may only be issued if one slot stays free.
    assign pending    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & (state != ST_FLUSH) & (pending <= 3'd1);

    always_comb begin
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        occ_nxt   = occ;
        if (pop) begin
            slot0_nxt = slot1;
            occ_nxt   = occ - 2'd1;
        end
        if (inflight) begin
            if (occ_nxt == 2'd0) begin
                slot0_nxt = fifo_rd_data;
            end else begin
                slot1_nxt = fifo_rd_data;
            end
            occ_nxt = occ_nxt + 2'd1;
        end
        // Flush wins over pop and landing; the landing word is dropped.
        if (flush || (state == ST_FLUSH)) begin
            occ_nxt = 2'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt = ST_FLUSH;
                end else if (fifo_rd_en) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (flush) begin
                    state_nxt = ST_FLUSH;
                end else if ((occ_nxt == 2'd0) && !fifo_rd_en) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!flush && !inflight) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            occ      <= occ_nxt;
            inflight <= fifo_rd_en;
            slot0    <= slot0_nxt;
            slot1    <= slot1_nxt;
            word_cnt <= word_cnt + CNT_W'(pop);
        end
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drains a synchronous FIFO read port (rd_en/empty, registered read data) and presents the words as a valid/ready stream.
- Handles the FIFO's one-cycle read latency with a 2-entry output skid buffer, so throughput is one word per cycle under continuous m_ready and no word is lost under back-pressure.
- Sits between the FIFO read side and any valid/ready consumer.
- Provides flush and a delivered-word counter.

Parameters:
- WIDTH, 8, data word width; must match the FIFO.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  FIFO read request
- fifo_rd_data  input  WIDTH  FIFO read data, valid the cycle after an accepted read
- m_valid  output  1  output word valid
- m_ready  input  1  consumer ready
- m_data  output  WIDTH  output word
- flush  input  1  level; discard buffered and in-flight data, stop reading
- busy  output  1  FSM not in IDLE
- word_cnt  output  CNT_W  count of completed output handshakes

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, word_cnt=0, occ=0, inflight=0, state IDLE. Reset mid-operation clears everything immediately; the in-flight word is lost.
- Read acceptance: a FIFO read is accepted at an edge iff fifo_rd_en=1 and fifo_empty=0.
  - inflight is set by an accepted read and means fifo_rd_data is valid in the following cycle.
  - That word is captured at the end of that cycle.
- Buffer model:
  - slot0 drives m_data; slot1 is the skid register; occ ranges 0..2.
  - m_valid = (occ != 0), registered.
  - pop = m_valid & m_ready.
- Issue rule (combinational):
  - fifo_rd_en = !fifo_empty & !flush & (state != FLUSH) & (occ + inflight - pop <= 1).
  - Steady state is occ=1, inflight=1, pop=1, which issues every cycle (no bubbles).
- Capture and pop ordering:
  - A pop shifts slot1 into slot0, occ-1.
  - A landing word goes to the lowest free slot after the pop is applied.
  - pop and landing in the same cycle leave occ unchanged.
  - Strict FIFO order; never overwrite a held word.
- Stability: while m_valid=1 and m_ready=0, m_data is held and m_valid stays 1. m_valid drops without a handshake only on flush or reset.
- Latency: with empty buffer and non-empty FIFO:
  - fifo_rd_en=1 in cycle N;
  - data on fifo_rd_data in N+1;
  - m_valid=1 with that word in N+2.
- FSM:
  - IDLE: occ=0, inflight=0. Go to STREAM on an accepted read. Go to FLUSH if flush=1.
  - STREAM: go to IDLE when, at an edge, occ becomes 0 and inflight becomes 0. Go to FLUSH if flush=1 at an edge.
  - FLUSH:
    - At entry, occ is cleared, so m_valid=0 from the next cycle.
    - A word landing at the entry edge or while in FLUSH is discarded.
    - fifo_rd_en is held at 0.
    - Return to IDLE when flush=0 and inflight=0.
  - flush has priority over pop and landing at the same edge. A handshake completing at the flush edge still counts in word_cnt.
- Counter: word_cnt increments on every pop and wraps modulo 2^CNT_W. Cleared only by reset, not by flush.
- busy = (state != IDLE).

Test Plan:
- Reset: assert rst_n=0 mid-stream with occ=2 -> next observation m_valid=0, fifo_rd_en=0, busy=0, word_cnt=0; after release, first delivered word is the next FIFO word, not a stale one.
- Streaming: FIFO preloaded 0x11..0x18, m_ready=1 -> first fifo_rd_en in cycle N, m_valid in N+2, then 8 consecutive beats 0x11..0x18 with no gaps; word_cnt=8; busy falls 1 cycle after the last beat.
- Back-pressure: FIFO full, m_ready=0 for 10 cycles -> exactly 2 reads accepted, m_data=0x11 held stable; after m_ready=1, the order continues 0x11, 0x12, 0x13... with no loss or duplication.
- Random: m_ready 50% random, 256 incrementing words written concurrently into the FIFO -> output sequence equals input exactly; occ never exceeds 2; word_cnt=256.
- Flush: with occ=2 and inflight=1, pulse flush 3 cycles -> m_valid=0 the cycle after the edge, fifo_rd_en=0 throughout, in-flight word never appears; after release, the next output is the following FIFO word; word_cnt unchanged.
- Wrap: CNT_W=4, 17 handshakes -> word_cnt=1.
